upsample2d: RTL and testbench

UPSAMPLE2D -- requirements
Module: upsample2d

---
 rtl/upsample2d_pkg.sv | 15 +
 rtl/upsample2d_line_buf.sv | 25 ++
 rtl/upsample2d.sv | 145 ++++++++++++++
 tb/tb_upsample2d.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/upsample2d_pkg.sv
// Shared sizing and state encoding for the 2x nearest-neighbour upsampler.
package upsample2d_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int LINE_BUF_SIZE = 52;
    localparam int DIM_W         = 9;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPEAT,
        DONE
    } state_t;

endpackage

// File: rtl/upsample2d_line_buf.sv
// One input line of pixels; synchronous write, combinational read.
module upsample2d_line_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 52,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample2d.sv
// 2x nearest-neighbour upsampler: each input row is emitted pixel-doubled,
// then replayed from the line buffer to form the second output row.
module upsample2d #(
    parameter int DATA_WIDTH    = upsample2d_pkg::DATA_WIDTH,
    parameter int LINE_BUF_SIZE = upsample2d_pkg::LINE_BUF_SIZE
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [upsample2d_pkg::DIM_W-1:0]    i_width,
    input  logic [upsample2d_pkg::DIM_W-1:0]    i_height,
    input  logic [DATA_WIDTH-1:0]               i_data,
    input  logic                                i_valid,
    output logic                                o_ready,
    output logic [DATA_WIDTH-1:0]               o_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_done
);
    import upsample2d_pkg::*;

    localparam int AW = $clog2(LINE_BUF_SIZE);

    state_t               state;
    logic [DIM_W-1:0]     w_q;
    logic [DIM_W-1:0]     h_q;
    logic [DIM_W-1:0]     x;
    logic [DIM_W-1:0]     y;
    logic                 phase;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 last_x;
    logic                 bad_dims;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // A new pixel may enter once the previous one has finished its second beat.
    assign o_ready  = (state == FILL) && (x < w_q) &&
                      (!o_valid || (phase && i_ready));
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;
    assign last_x   = (x == w_q - 1'b1);
    assign bad_dims = (i_width == '0) || (i_height == '0) ||
                      (i_width > DIM_W'(LINE_BUF_SIZE));
    assign wr_addr  = x[AW-1:0];
    // Prefetch the next replay entry; entry 0 is read while leaving FILL.
    assign rd_addr  = (state == REPEAT && !last_x) ? AW'(x + 1'b1) : '0;

    upsample2d_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LINE_BUF_SIZE),
        .AW         (AW)
    ) u_line_buf (
        .i_clk   (i_clk),
        .wr_en   (in_xfer),
        .wr_addr (wr_addr),
        .wr_data (i_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            x       <= '0;
            y       <= '0;
            phase   <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        w_q   <= i_width;
                        h_q   <= i_height;
                        x     <= '0;
                        y     <= '0;
                        phase <= 1'b0;
                        if (bad_dims) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (in_xfer) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        phase   <= 1'b0;
                        x       <= x + 1'b1;
                    end else if (out_xfer) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else if (x == w_q) begin
                            state  <= REPEAT;
                            x      <= '0;
                            phase  <= 1'b0;
                            o_data <= rd_data;
                        end else begin
                            o_valid <= 1'b0;
                            phase   <= 1'b0;
                        end
                    end
                end
                REPEAT: begin
                    if (out_xfer) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (!last_x) begin
                                x      <= x + 1'b1;
                                o_data <= rd_data;
                            end else begin
                                o_valid <= 1'b0;
                                x       <= '0;
                                if (y == h_q - 1'b1) begin
                                    state  <= DONE;
                                    o_done <= 1'b1;
                                end else begin
                                    y     <= y + 1'b1;
                                    state <= FILL;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample2d.sv
// Randomised self-checking bench for upsample2d against a raster-order model.
module tb_upsample2d;
    import upsample2d_pkg::*;

    localparam int DW = upsample2d_pkg::DATA_WIDTH;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [8:0]    i_width;
    logic [8:0]    i_height;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] exp_q[$];

    upsample2d dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_width  (i_width),
        .i_height (i_height),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic fill_random(input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back(DW'($urandom));
    endtask

    // vmode: 0 always valid, 1 random valid, 2 valid every other cycle.
    task automatic run_frame(input int w, input int h, input int rdy_pct,
                             input int vmode, input int mid_cyc,
                             input int abort_at);
        int acc = 0;
        int ocnt = 0;
        int cyc = 0;
        int yy;
        int kk;
        bit ok;
        bit legal;
        bit out_x;
        bit in_x;
        bit prev_stall = 0;
        bit prev_acc = 0;
        bit done_seen = 0;
        logic [DW-1:0] prev_d = '0;
        logic [DW-1:0] prev_px = '0;

        ok = (w > 0) && (h > 0) && (w <= LINE_BUF_SIZE);
        exp_q.delete();
        if (!ok) in_q.delete();
        else begin
            for (int r = 0; r < 2 * h; r++)
                for (int c = 0; c < 2 * w; c++)
                    exp_q.push_back(in_q[(r / 2) * w + c / 2]);
        end

        @(negedge i_clk);
        i_start  = 1'b1;
        i_width  = 9'(w);
        i_height = 9'(h);
        i_valid  = 1'b0;
        i_ready  = 1'b0;

        forever begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (done_seen) begin
                check("done_pulse", 32'(o_done), 0);
                break;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(o_valid), 1);
                check("hold_data", 32'(o_data), 32'(prev_d));
            end
            if (prev_acc) begin
                check("lat_valid", 32'(o_valid), 1);
                check("lat_data", 32'(o_data), 32'(prev_px));
            end
            if (!ok) begin
                check("bad_valid", 32'(o_valid), 0);
                check("bad_ready", 32'(o_ready), 0);
            end
            if (o_done) begin
                done_seen = 1;
                check("done_left", 32'(exp_q.size() + in_q.size()), 0);
                if (!ok) check("done_lat", 32'(cyc < 3), 1);
            end
            if (abort_at > 0 && ocnt >= abort_at) begin
                i_rst   = 1'b1;
                i_valid = 1'b0;
                i_ready = 1'b1;
                @(negedge i_clk);
                i_rst = 1'b0;
                check("rst_valid", 32'(o_valid), 0);
                check("rst_ready", 32'(o_ready), 0);
                check("rst_done", 32'(o_done), 0);
                check("rst_data", 32'(o_data), 0);
                for (int i = 0; i < 3; i++) begin
                    i_valid = 1'b1;
                    #1;
                    check("idle_ready", 32'(o_ready), 0);
                    @(negedge i_clk);
                    check("idle_done", 32'(o_done), 0);
                    check("idle_valid", 32'(o_valid), 0);
                end
                i_valid = 1'b0;
                return;
            end
            if (cyc == mid_cyc) begin
                i_start  = 1'b1;
                i_width  = 9'd1;
                i_height = 9'd1;
            end
            i_ready = ($urandom_range(99) < rdy_pct);
            unique case (vmode)
                0: i_valid = 1'b1;
                1: i_valid = 1'($urandom_range(1));
                default: i_valid = 1'(cyc % 2);
            endcase
            i_data = (in_q.size() > 0) ? in_q[0] : DW'($urandom);
            #1;
            out_x = o_valid && i_ready;
            in_x  = i_valid && o_ready;
            if (in_x) begin
                yy = ok ? acc / w : 0;
                kk = ok ? acc % w : 0;
                legal = ok && (acc < w * h) &&
                        ((ocnt == 4 * w * yy + 2 * kk) ||
                         (kk > 0 && out_x && ocnt == 4 * w * yy + 2 * kk - 1));
                check("in_legal", 32'(legal), 1);
                if (in_q.size() > 0) void'(in_q.pop_front());
                acc++;
            end
            prev_acc = in_x;
            prev_px  = i_data;
            if (out_x) begin
                if (exp_q.size() == 0) check("extra_beat", 32'(o_valid), 0);
                else check("pixel", 32'(o_data), 32'(exp_q.pop_front()));
                ocnt++;
            end
            prev_stall = o_valid && !i_ready;
            prev_d     = o_data;
            cyc++;
            if (cyc > 5000) begin
                check("timeout", 32'(done_seen), 1);
                break;
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
    endtask

    initial begin
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_width  = '0;
        i_height = '0;
        i_data   = '0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        repeat (2) @(negedge i_clk);
        check("reset_valid", 32'(o_valid), 0);
        check("reset_ready", 32'(o_ready), 0);
        check("reset_done", 32'(o_done), 0);
        check("reset_data", 32'(o_data), 0);
        i_rst = 1'b0;

        in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(2, 2, 100, 0, -1, 0);

        fill_random(52 * 3);
        run_frame(52, 3, 50, 0, -1, 0);

        run_frame(53, 2, 100, 0, -1, 0);
        run_frame(0, 3, 100, 0, -1, 0);

        fill_random(16);
        run_frame(4, 4, 70, 1, 10, 0);

        fill_random(12);
        run_frame(4, 3, 100, 0, -1, 25);
        in_q = '{16'd7, 16'hFFFB};
        run_frame(2, 1, 100, 0, -1, 0);

        fill_random(6);
        run_frame(3, 2, 100, 2, -1, 0);

        for (int t = 0; t < 4; t++) begin
            int w;
            int h;
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 4);
            fill_random(w * h);
            run_frame(w, h, $urandom_range(30, 100), 1, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
